// File: rtl/cnt_bus_arbiter_pkg.sv
// rtl/cnt_bus_arbiter_pkg.sv - shared parameters and tag type for the cnt_bus read-port arbiter
//
// Purpose: widths and latency of the controller-register BRAM read port, plus
//          the tag carried through the read-latency pipeline.
// Ports:   none (package).
package cnt_bus_arbiter_pkg;

  localparam int CNT_ADDR_W       = 8;
  localparam int CNT_DATA_W       = 16;
  localparam int CNT_READ_LATENCY = 2;

  // Tag id is sized for the largest legal requester count (8) so one tag type
  // serves every NUM_REQ configuration.
  localparam int CNT_MAX_REQ = 8;
  localparam int CNT_ID_W    = $clog2(CNT_MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [CNT_ID_W-1:0] id;
  } cnt_tag_t;

endpackage

// File: rtl/cnt_bus_arbiter_rr_arbiter.sv
// rtl/cnt_bus_arbiter_rr_arbiter.sv - round-robin one-hot grant with rotating priority pointer
//
// Purpose: combinational one-hot grant from req and a priority pointer; the
//          pointer moves to one past the winner on an accepted grant.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset (pointer to 0)
//   req     in   NUM_REQ request vector
//   accept  in   grant was taken this cycle
//   gnt     out  NUM_REQ one-hot grant, combinational
module cnt_bus_arbiter_rr_arbiter
  import cnt_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     win;
  logic [2*NUM_REQ-1:0] req2;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_gnt;
  logic [2*NUM_REQ-1:0] gnt2;

  // Rotate req so that index ptr sits at bit 0, pick the lowest set bit,
  // then rotate the one-hot result back into requester order.
  always_comb begin
    req2    = {req, req};
    rot_req = NUM_REQ'(req2 >> ptr);
    rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
    gnt2    = {rot_gnt, rot_gnt} << ptr;
    gnt     = gnt2[2*NUM_REQ-1:NUM_REQ];
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

endmodule

// File: rtl/cnt_bus_arbiter.sv
// rtl/cnt_bus_arbiter.sv - shares the cnt_bus BRAM read port among NUM_REQ requesters
//
// Purpose: one accepted read per cycle, registered CNT address, fixed-latency
//          return of data with a one-hot per-requester valid strobe.
// Build option: CNT_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
//               wins, no pointer); default is round-robin.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   req       in   NUM_REQ per-requester read request
//   addr      in   NUM_REQ*ADDR_W packed addresses, slice i for req[i]
//   gnt       out  NUM_REQ one-hot grant, combinational
//   rvalid    out  NUM_REQ one-hot read-data strobe, registered
//   rdata     out  DATA_W shared read data, registered
//   cnt_addr  out  ADDR_W address to cnt_bus, registered
//   cnt_dout  in   DATA_W data from cnt_bus
module cnt_bus_arbiter
  import cnt_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = CNT_READ_LATENCY,
  parameter int ADDR_W       = CNT_ADDR_W,
  parameter int DATA_W       = CNT_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         cnt_addr,
  input  logic [DATA_W-1:0]         cnt_dout
);

  logic                accept;
  logic [CNT_ID_W-1:0] acc_id;
  logic [ADDR_W-1:0]   acc_addr;

  // Stage s holds the tag accepted s edges ago; the last stage lines up with
  // valid cnt_dout for that read.
  cnt_tag_t pipe [0:READ_LATENCY];

`ifdef CNT_ARB_FIXED_PRIO_EN
  assign gnt = req & (~req + NUM_REQ'(1));
`else
  cnt_bus_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );
`endif

  assign accept = |(req & gnt);

  always_comb begin
    acc_id   = '0;
    acc_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        acc_id   = CNT_ID_W'(i);
        acc_addr = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_addr <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      for (int s = 0; s <= READ_LATENCY; s++) begin
        pipe[s] <= '0;
      end
    end else begin
      if (accept) cnt_addr <= acc_addr;

      pipe[0].valid <= accept;
      pipe[0].id    <= acc_id;
      for (int s = 1; s <= READ_LATENCY; s++) begin
        pipe[s] <= pipe[s-1];
      end

      if (pipe[READ_LATENCY].valid) begin
        rvalid <= NUM_REQ'(1) << pipe[READ_LATENCY].id;
        rdata  <= cnt_dout;
      end else begin
        rvalid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cnt_bus_arbiter.sv
// tb/tb_cnt_bus_arbiter.sv - directed self-checking bench for cnt_bus_arbiter with a 2-cycle BRAM model
module tb_cnt_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] addr;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [15:0] rdata;
  logic [7:0]  cnt_addr;
  logic [15:0] cnt_dout;

  logic [7:0]  a [4];
  logic [15:0] mem [256];
  logic [15:0] s1, s2;

  // expected-value model
  logic        pv  [3];
  logic [1:0]  pid [3];
  logic [7:0]  pad [3];
  logic [3:0]  m_rv;
  logic [15:0] m_rd;
  logic [7:0]  m_ca;

  int n_pass;
  int n_tot;

  assign addr = {a[3], a[2], a[1], a[0]};

  cnt_bus_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .cnt_addr (cnt_addr),
    .cnt_dout (cnt_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM read port: address registered, then output registered
  always @(posedge clk) begin
    s1 <= mem[cnt_addr];
    s2 <= s1;
  end
  assign cnt_dout = s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int s = 0; s < 3; s++) begin
      pv[s] = 1'b0; pid[s] = 2'd0; pad[s] = 8'd0;
    end
    m_rv = 4'd0; m_rd = 16'd0; m_ca = 8'd0;
  endtask

  // One cycle: drive req, check at negedge, advance the model at the edge.
  task automatic tick(input logic [3:0] r, input logic [3:0] eg, input string tag);
    logic [1:0] idx;
    req = r;
    @(negedge clk);
    check({tag, "_gnt"},      32'(gnt),      32'(eg));
    check({tag, "_rvalid"},   32'(rvalid),   32'(m_rv));
    check({tag, "_rdata"},    32'(rdata),    32'(m_rd));
    check({tag, "_cnt_addr"}, 32'(cnt_addr), 32'(m_ca));
    @(posedge clk);
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (eg[i]) idx = 2'(i);
    if (pv[2]) begin
      m_rv = 4'b0001 << pid[2];
      m_rd = mem[pad[2]];
    end else begin
      m_rv = 4'd0;
    end
    pv[2] = pv[1]; pid[2] = pid[1]; pad[2] = pad[1];
    pv[1] = pv[0]; pid[1] = pid[0]; pad[1] = pad[0];
    pv[0] = (eg != 4'd0); pid[0] = idx; pad[0] = a[idx];
    if (eg != 4'd0) m_ca = a[idx];
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4; i++) tick(4'b0000, 4'b0000, tag);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) a[i] = 8'd0;
    model_clear();
    req   = 4'd0;
    rst_n = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_gnt",      32'(gnt),      32'h0);
    check("reset_rvalid",   32'(rvalid),   32'h0);
    check("reset_rdata",    32'(rdata),    32'h0);
    check("reset_cnt_addr", 32'(cnt_addr), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifndef CNT_ARB_FIXED_PRIO_EN
    // full contention, round-robin from ptr 0
    for (int i = 0; i < 4; i++) a[i] = 8'(i);
    tick(4'b1111, 4'b0001, "rr0");
    tick(4'b1111, 4'b0010, "rr1");
    tick(4'b1111, 4'b0100, "rr2");
    tick(4'b1111, 4'b1000, "rr3");
    tick(4'b1111, 4'b0001, "rr4");
    tick(4'b1111, 4'b0010, "rr5");
    tick(4'b1111, 4'b0100, "rr6");
    tick(4'b1111, 4'b1000, "rr7");
    drain("rr_drain");
`endif

    // single read from requester 1
    a[1] = 8'h2A;
    tick(4'b0010, 4'b0010, "single");
    drain("single_drain");

`ifndef CNT_ARB_FIXED_PRIO_EN
    // withdrawal: ptr is 2 here
    a[0] = 8'hE0; a[2] = 8'h22;
    tick(4'b0101, 4'b0100, "wd_grant");
    tick(4'b0100, 4'b0100, "wd_drop");
    drain("wd_drain");
    // ptr held at 3 through idle cycles
    a[3] = 8'h33;
    tick(4'b1001, 4'b1000, "wd_ptr_hold");
    drain("wd_drain2");
`else
    // fixed priority: requester 1 always wins over 2 and 3
    a[1] = 8'h55; a[2] = 8'h66; a[3] = 8'h77;
    for (int i = 0; i < 6; i++) tick(4'b1110, 4'b0010, "fixed");
    drain("fixed_drain");
`endif

    // sweep 0..255 back-to-back on requester 0
    for (int n = 0; n < 256; n++) begin
      a[0] = 8'(n);
      tick(4'b0001, 4'b0001, "sweep");
    end
    drain("sweep_drain");

    // reset with a read in flight
    a[0] = 8'h77;
    tick(4'b0001, 4'b0001, "rst_acc");
    tick(4'b0000, 4'b0000, "rst_pre");
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_async_rvalid",   32'(rvalid),   32'h0);
    check("rst_async_cnt_addr", 32'(cnt_addr), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold_rvalid",   32'(rvalid),   32'h0);
      check("rst_hold_cnt_addr", 32'(cnt_addr), 32'h0);
      check("rst_hold_rdata",    32'(rdata),    32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drain("rst_post");
    a[1] = 8'h3C; a[3] = 8'hFE;
    tick(4'b1010, 4'b0010, "rst_next");
    drain("rst_next_drain");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cnt_bus_arbiter.md
Name: cnt_bus_arbiter

Overview:
- Shares the single read port of the controller-register BRAM (cnt_bus: 8-bit ADDR, 16-bit DOUT, fixed read latency) among N internal requesters, e.g. mod, STM and silencer config fetch.
- Provides per-requester valid/grant handshake, round-robin arbitration, one accepted read per cycle, and data returned with a per-requester valid strobe.
- Sits between memory's CNT_BUS out_port and the consumer blocks.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- READ_LATENCY, 2, cycles from CNT_ADDR change to valid CNT_DOUT.
- ADDR_W, 8, cnt BRAM address width.
- DATA_W, 16, cnt BRAM data width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NUM_REQ  per-requester read request (valid).
- ADDR  in  NUM_REQ*ADDR_W  packed request addresses; slice i belongs to REQ[i].
- GNT  out  NUM_REQ  one-hot, combinational; REQ[i]&GNT[i] at a posedge = accepted.
- RVALID  out  NUM_REQ  one-hot read-data strobe, registered.
- RDATA  out  DATA_W  read data, shared, registered.
- CNT_ADDR  out  ADDR_W  to cnt_bus ADDR, registered.
- CNT_DOUT  in  DATA_W  from cnt_bus DOUT.

Behaviour:
- Reset (async assert, sync release): GNT=0, RVALID=0, RDATA=0, CNT_ADDR=0, rr pointer=0, latency pipeline cleared.
- GNT is a pure function of REQ and the rr pointer; at most one bit set. GNT=0 when REQ=0.
- Round-robin: search starts at index ptr and wraps modulo NUM_REQ. The first set REQ wins. On acceptance of i, ptr<=(i+1)%NUM_REQ. With no acceptance, ptr holds.
- Requester rules:
  - ADDR slice must be stable while REQ high and not yet granted.
  - REQ may drop before grant (withdrawal, no side effect).
  - REQ held high after acceptance means a new request; the same address may be read again.
- On acceptance at edge k: CNT_ADDR<=ADDR[i], and tag (valid, i) enters a READ_LATENCY+1 deep shift pipeline.
  - At edge k+READ_LATENCY+1: RDATA<=CNT_DOUT, RVALID<=onehot(i) for exactly one cycle.
  - Latency from accept edge to RVALID high: READ_LATENCY+1 cycles.
- Throughput: one accept per cycle; back-to-back accepts give back-to-back RVALID in order of acceptance.
- Idle (no accept): CNT_ADDR holds last value, a zero tag enters the pipeline, RVALID=0, RDATA holds last value.
- Simultaneous REQ from all: each requester granted once every NUM_REQ cycles. Worst-case wait is NUM_REQ-1 cycles.
- Reset mid-operation: in-flight tags dropped, no RVALID after reset release for pre-reset accepts.
- ADDR wrap: address width is fixed; no arithmetic is done on it, so 8'hFF is legal.

Optional Feature:
- CNT_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. The ptr register is removed and GNT = lowest set REQ bit.
  - Undefined (default): round-robin as above.
  - Latency and RVALID behaviour are identical in both builds.

Decomposition:
- Add to the shared params package: CNT_ADDR_W=8, CNT_DATA_W=16, CNT_READ_LATENCY=2.
- Add a typedef cnt_tag_t {logic valid; logic [$clog2(NUM_REQ)-1:0] id;} to the same package.
- One natural sub-module: rr_arbiter (REQ, accept → one-hot GNT, ptr update), replaced in-line by a priority encoder under CNT_ARB_FIXED_PRIO_EN.

Test Plan:
- Single read: BRAM preloaded with random words; REQ[1]=1, ADDR[1]=8'h2A accepted at edge 10 → RVALID=4'b0010 during the cycle after edge 13, RDATA=mem[8'h2A], CNT_ADDR=8'h2A after edge 10.
- Full contention, round-robin: REQ=4'b1111 held, ADDR[i]=i → GNT sequence 0001,0010,0100,1000,0001…. RVALID follows the same sequence 3 cycles later with RDATA=mem[i].
- Sweep: requester 0 streams ADDR 0..255 back-to-back → 256 consecutive RVALID[0] pulses with RDATA=mem[n]; no gaps; wrap 8'hFF→8'h00 correct.
- Withdrawal: REQ=4'b0101 with ptr=2 → GNT=0100. Drop REQ[0] before its grant → no RVALID[0] ever appears, ptr advances only on accept.
- Reset mid-flight: accept at edge 20, assert RST_N=0 at edge 21 for 2 cycles → RVALID stays 0 throughout and after release, CNT_ADDR=0, next grant goes to the lowest set REQ from ptr=0.
- With CNT_ARB_FIXED_PRIO_EN: REQ=4'b1110 held → GNT=0010 every cycle, requesters 2 and 3 starved, RVALID[1] every cycle after 3-cycle latency.
